riscv_mem_arbiter: RTL
======================

# riscv_mem_arbiter

Shares one single-port unified instruction/data memory between the fetch stage and the memory-access stage of the RISC-V core. It grants one requester at a time and drives the memory port for one cycle. It waits a fixed memory latency, then returns read data with a one-cycle acknowledge and raises stall toward the core while a request is pending. It sits inside `RISCV_Top`, between the pipeline and the memory model.

## Interface
- `MEM_LAT`, 1: cycles from `mem_en` to valid `mem_rdata`; legal range ≥1.
- `AW`, 32: address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_ack`.
- `if_addr` in AW: fetch byte address.
- `if_rdata` out 32: fetched word; valid in the `if_ack` cycle and held until the next fetch ack.
- `if_ack` out 1: one-cycle completion pulse.
- `if_stall` out 1: `if_req & ~if_ack`.
- `dm_req` in 1: data request; held with all `dm_*` fields until `dm_ack`.
- `dm_we` in 1: 1 = store.
- `dm_be` in 4: byte enables.
- `dm_addr` in AW: data address.
- `dm_wdata` in 32: store data.
- `dm_rdata` out 32: load data; valid in the `dm_ack` cycle and held.
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_stall` out 1: `dm_req & ~dm_ack`.
- `mem_en` out 1: one-cycle access strobe.
- `mem_we` out 1: write strobe, qualified by `mem_en`.
- `mem_be` out 4: byte enables; 4'hF for fetches.
- `mem_addr` out AW: access address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation
- **FSM states:**
  - IDLE: no access in flight.
  - WAIT: access in flight, timer running.
- **IDLE:**
  - If any request is present, select a grantee (see Configuration).
  - Register `mem_en`=1 plus the grantee's address, we, be and wdata for exactly one cycle.
  - Load the timer with `MEM_LAT`.
  - Record the grantee and go to WAIT.
- **WAIT:**
  - `mem_en`=0; the timer decrements each cycle.
  - At the edge where the timer reaches 1, capture `mem_rdata` into the grantee's rdata register, pulse that grantee's ack next cycle, and return to IDLE.
- **Re-arbitration:** the ack cycle is an IDLE cycle, but the arbiter ignores requests in it. The requester drops or changes its req at the ack edge, so the same transaction is never granted twice.
- **Stores:** complete with ack after the same `MEM_LAT`; rdata registers are unchanged on a store.
- **Timer width:** $clog2(MEM_LAT+1); no wrap possible.
- **Reset values:** all outputs 0, including `if_rdata`/`dm_rdata`; state IDLE; `last_grant` = IF.
- **Reset mid-transaction:** the transaction is abandoned with no ack; `mem_en` is 0 from the next cycle.
- **Requests dropped before ack:** protocol violation, undefined result. An assertion fires under simulation.

## Timing
- Request seen in IDLE at cycle N: `mem_en` at N+1, ack at N+1+`MEM_LAT`.
- Single-requester throughput: one access per `MEM_LAT`+2 cycles.
- At most one ack per cycle; `if_ack` and `dm_ack` are never simultaneous.
- Simultaneous `if_req` and `dm_req`: exactly one is granted; the other stalls until its own ack.

## Configuration
- `RISCV_ARB_RR_EN` defined: round-robin.
  - On a tie, grant the requester other than `last_grant`; `last_grant` updates on each grant.
  - After reset, the first tie goes to data.
- Undefined: fixed priority, data over fetch. The older instruction is always served first; `last_grant` is not implemented.

## Structure
- Package `riscv_arb_pkg` holds:
  - state encoding (IDLE, WAIT)
  - grantee encoding (GNT_IF, GNT_DM)
  - byte-enable constant `BE_WORD`=4'hF
- One sub-module: `riscv_arb_lat_timer` (load/decrement/done counter parameterised by `MEM_LAT`).

## Test plan
- **Reset:** `rst`=1 for 2 cycles with both reqs high. Required: all outputs 0, no `mem_en` until 1 cycle after `rst` falls.
- **Single fetch, MEM_LAT=1:** `if_addr`=0x10, memory returns 0x00500093. Required: `mem_en` at N+1, `if_ack` at N+2, `if_rdata`=0x00500093, `if_stall` high N..N+1.
- **Store then load, MEM_LAT=3:** `dm_we`=1, addr 0x200, wdata 0xDEADBEEF, be 4'b0011, then a load from the same address. Required: `mem_be`=4'b0011, `dm_ack` 4 cycles after each request, `dm_rdata` unchanged by the store.
- **Tie, macro undefined:** both reqs held for 4 transactions. Required: data granted first; fetch granted only once `dm_req` is low.
- **Tie, `RISCV_ARB_RR_EN` defined:** both reqs held continuously. Required: grant order DM, IF, DM, IF; never two acks in one cycle.
- **Reset in WAIT, MEM_LAT=4:** assert `rst` 2 cycles after `mem_en`. Required: no ack ever issued; state IDLE; next request serviced normally.

Source files
------------

// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_e  : arbiter FSM encoding (IDLE, WAIT)
//   grant_e      : which requester owns the access in flight (GNT_IF, GNT_DM)
//   BE_WORD      : byte-enable pattern used for instruction fetches
//   pick_grantee : chooses the grantee from the two request lines
package riscv_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  // A lone requester always wins; tie_to_if only matters when both ask.
  function automatic grant_e pick_grantee(input logic if_req,
                                          input logic dm_req,
                                          input logic tie_to_if);
    grant_e g;
    if (if_req && dm_req) begin
      g = tie_to_if ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      g = GNT_DM;
    end else begin
      g = GNT_IF;
    end
    return g;
  endfunction

endpackage

// File: rtl/riscv_arb_checker.sv
// riscv_arb_checker
// Protocol checker for the arbiter's requester side.
//   A pending request (req without ack) must still be present next cycle,
//   data requests must keep their fields stable while pending, and the
//   two acks must never coincide.
module riscv_arb_checker #(
  parameter int AW = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          if_req,
  input logic          if_ack,
  input logic          dm_req,
  input logic          dm_ack,
  input logic          dm_we,
  input logic [3:0]    dm_be,
  input logic [AW-1:0] dm_addr,
  input logic [31:0]   dm_wdata
);

  a_if_held : assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_ack) |=> if_req);

  a_dm_held : assert property (@(posedge clk) disable iff (rst)
    (dm_req && !dm_ack) |=> (dm_req && $stable({dm_we, dm_be, dm_addr, dm_wdata})));

  a_one_ack : assert property (@(posedge clk) disable iff (rst)
    !(if_ack && dm_ack));

endmodule

// File: rtl/riscv_arb_lat_timer.sv
// riscv_arb_lat_timer
// Down-counter measuring the fixed memory latency of one access.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (counter cleared)
//   load : start of an access; counter loads MEM_LAT
//   done : high during the last latency cycle (count == 1)
module riscv_arb_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(MEM_LAT + 1);

  logic [TW-1:0] count;

  // Load on grant, then count down to zero and park there.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {TW{1'b0}};
    end else if (load) begin
      count <= TW'(MEM_LAT);
    end else if (count != {TW{1'b0}}) begin
      count <= count - TW'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == TW'(1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one single-port unified memory between instruction fetch and data
// access. One access in flight at a time; each access strobes the memory
// port for one cycle, waits MEM_LAT cycles, then acks its requester.
// Build option: define RISCV_ARB_RR_EN for round-robin tie breaking;
// otherwise data always wins a tie (fixed priority).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   if_req/if_addr                    : fetch request (held until if_ack)
//   if_rdata/if_ack/if_stall          : fetch response
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata : data request (held until dm_ack)
//   dm_rdata/dm_ack/dm_stall          : data response
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata : memory port
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ack,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  arb_state_e state;
  grant_e     grantee;
  grant_e     sel;
  logic       tie_to_if;
  logic       start;
  logic       timer_done;

`ifdef RISCV_ARB_RR_EN
  grant_e last_grant;

  // Remember the most recent grantee so the next tie goes to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_IF;
    end else if (start) begin
      last_grant <= sel;
    end else begin
      last_grant <= last_grant;
    end
  end
`endif

  // Grant selection. Requests are ignored in the ack cycle because the
  // requester only moves on to its next transaction at the ack edge.
  always_comb begin
`ifdef RISCV_ARB_RR_EN
    tie_to_if = (last_grant == GNT_DM);
`else
    tie_to_if = 1'b0;
`endif
    sel   = pick_grantee(if_req, dm_req, tie_to_if);
    start = (state == IDLE) && !if_ack && !dm_ack && (if_req || dm_req);
  end

  riscv_arb_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(start),
    .done(timer_done)
  );

  // Arbiter FSM: launch the access, wait out the latency, capture and ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grantee   <= GNT_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= 32'h0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= 32'h0;
      dm_rdata  <= 32'h0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_en  <= 1'b1;
            grantee <= sel;
            state   <= WAIT;
            if (sel == GNT_DM) begin
              mem_we    <= dm_we;
              mem_be    <= dm_be;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= BE_WORD;
              mem_addr  <= if_addr;
              mem_wdata <= 32'h0;
            end
          end
        end
        WAIT: begin
          if (timer_done) begin
            state <= IDLE;
            if (grantee == GNT_DM) begin
              dm_ack <= 1'b1;
              // A store leaves the last load result in place.
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall is held low in reset so every output reads zero there.
  assign if_stall = if_req & ~if_ack & ~rst;
  assign dm_stall = dm_req & ~dm_ack & ~rst;

endmodule
